// File: rtl/multicycle_io_buffer_if.sv
// CPU request/response, UART and status signals of multicycle_io_buffer.
// master = CPU/UART side, slave = the buffer itself.
interface multicycle_io_buffer_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16
);
    // CPU input request
    logic                      in_req;
    logic                      in_word;
    logic                      in_valid;
    logic [XLEN-1:0]           in_data;
    // CPU output request
    logic                      out_req;
    logic                      out_word;
    logic [XLEN-1:0]           out_data;
    logic                      out_ready;
    logic                      stall;
    // UART
    logic [7:0]                rx_data;
    logic                      rx_ready;
    logic [7:0]                tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    // Status
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic                      rx_overflow;

    modport master (
        output in_req, in_word, out_req, out_word, out_data, rx_data, rx_ready, tx_busy,
        input  in_valid, in_data, out_ready, stall, tx_data, tx_start,
               rx_count, tx_count, rx_overflow
    );

    modport slave (
        input  in_req, in_word, out_req, out_word, out_data, rx_data, rx_ready, tx_busy,
        output in_valid, in_data, out_ready, stall, tx_data, tx_start,
               rx_count, tx_count, rx_overflow
    );
endinterface

// File: rtl/multicycle_io_buffer.sv
// Byte-wide UART buffering for a CPU: an RX FIFO assembled into bytes/words on request,
// a TX FIFO filled from byte/word output requests and drained into a UART transmitter.
module multicycle_io_buffer #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16
) (
    input logic                   clk,
    input logic                   rstn,
    multicycle_io_buffer_if.slave bus
);
    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned KW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned NLW = $clog2(NB + 1);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned TAW = $clog2(TX_DEPTH);

    localparam logic [RAW:0]    RX_FULL = (RAW + 1)'(RX_DEPTH);
    localparam logic [TAW:0]    TX_FULL = (TAW + 1)'(TX_DEPTH);
    localparam logic [KW-1:0]   K_LAST  = KW'(NB - 1);
    localparam logic [NLW-1:0]  NL_WORD = NLW'(NB);
    localparam logic [NLW-1:0]  NL_ONE  = NLW'(1);

    typedef enum logic [1:0] {I_IDLE, I_COLLECT, I_DONE} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_PUSH, O_DONE}    out_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT}   tx_state_t;

    // RX FIFO
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RAW-1:0] rx_wptr_q, rx_rptr_q;
    logic [RAW:0]   rx_cnt_q;
    logic           rx_ovf_q;
    logic           rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]     rx_head;

    // TX FIFO
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TAW-1:0] tx_wptr_q, tx_rptr_q;
    logic [TAW:0]   tx_cnt_q;
    logic           tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]     tx_head;

    // Input FSM
    in_state_t       istate_q;
    logic [KW-1:0]   k_q;
    logic            iword_q;
    logic            in_valid_q;
    logic [XLEN-1:0] in_data_q;

    // Output FSM
    out_state_t      ostate_q;
    logic [XLEN-1:0] oshift_q;
    logic [NLW-1:0]  oleft_q;
    logic            out_ready_q;

    // TX drain FSM
    tx_state_t       tstate_q;
    logic [7:0]      tx_data_q;
    logic            tx_start_q;

    assign rx_full  = (rx_cnt_q == RX_FULL);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_head  = rx_mem[rx_rptr_q];
    assign rx_pop   = (istate_q == I_COLLECT) && !rx_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte
    assign rx_push  = bus.rx_ready && (!rx_full || rx_pop);

    assign tx_full  = (tx_cnt_q == TX_FULL);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_head  = tx_mem[tx_rptr_q];
    assign tx_push  = (ostate_q == O_PUSH) && !tx_full;
    assign tx_pop   = (tstate_q == T_IDLE) && !tx_empty && !bus.tx_busy;

    // RX storage write; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= bus.rx_data;
    end

    // RX pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            rx_ovf_q  <= 1'b0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            unique case ({rx_push, rx_pop})
                2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
                2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
                default: rx_cnt_q <= rx_cnt_q;
            endcase
            if (bus.rx_ready && rx_full && !rx_pop) rx_ovf_q <= 1'b1;
        end
    end

    // TX storage write
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= oshift_q[7:0];
    end

    // TX pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
            unique case ({tx_push, tx_pop})
                2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
                2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
                default: tx_cnt_q <= tx_cnt_q;
            endcase
        end
    end

    // Input FSM: gather one byte or XLEN/8 bytes (LSB first) from the RX FIFO
    always_ff @(posedge clk) begin
        if (!rstn) begin
            istate_q   <= I_IDLE;
            k_q        <= '0;
            iword_q    <= 1'b0;
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
        end else begin
            in_valid_q <= 1'b0;
            unique case (istate_q)
                I_IDLE: begin
                    if (bus.in_req) begin
                        k_q      <= '0;
                        iword_q  <= bus.in_word;
                        istate_q <= I_COLLECT;
                    end
                end
                I_COLLECT: begin
                    if (!rx_empty) begin
                        if (iword_q) in_data_q[{k_q, 3'b000} +: 8] <= rx_head;
                        else         in_data_q <= XLEN'(rx_head);
                        k_q <= k_q + 1'b1;
                        if (!iword_q || (k_q == K_LAST)) begin
                            istate_q   <= I_DONE;
                            in_valid_q <= 1'b1;
                        end
                    end
                end
                I_DONE:  istate_q <= I_IDLE;
                default: istate_q <= I_IDLE;
            endcase
        end
    end

    // Output FSM: snapshot the request, then feed bytes LSB first into the TX FIFO
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ostate_q    <= O_IDLE;
            oshift_q    <= '0;
            oleft_q     <= '0;
            out_ready_q <= 1'b0;
        end else begin
            out_ready_q <= 1'b0;
            unique case (ostate_q)
                O_IDLE: begin
                    if (bus.out_req) begin
                        oshift_q <= bus.out_data;
                        oleft_q  <= bus.out_word ? NL_WORD : NL_ONE;
                        ostate_q <= O_PUSH;
                    end
                end
                O_PUSH: begin
                    if (!tx_full) begin
                        oshift_q <= oshift_q >> 8;
                        oleft_q  <= oleft_q - 1'b1;
                        if (oleft_q == NL_ONE) begin
                            ostate_q    <= O_DONE;
                            out_ready_q <= 1'b1;
                        end
                    end
                end
                O_DONE:  ostate_q <= O_IDLE;
                default: ostate_q <= O_IDLE;
            endcase
        end
    end

    // TX drain FSM: one start pulse per byte, then wait out the transmitter's busy period
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tstate_q   <= T_IDLE;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            unique case (tstate_q)
                T_IDLE: begin
                    if (tx_pop) begin
                        tx_data_q  <= tx_head;
                        tx_start_q <= 1'b1;
                        tstate_q   <= T_START;
                    end
                end
                T_START: tstate_q <= T_WAIT;
                T_WAIT:  if (!bus.tx_busy) tstate_q <= T_IDLE;
                default: tstate_q <= T_IDLE;
            endcase
        end
    end

    assign bus.in_valid    = in_valid_q;
    assign bus.in_data     = in_data_q;
    assign bus.out_ready   = out_ready_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.rx_count    = rx_cnt_q;
    assign bus.tx_count    = tx_cnt_q;
    assign bus.rx_overflow = rx_ovf_q;
    // Stall drops in the completion cycle so the CPU can retire the request
    assign bus.stall = (((istate_q != I_IDLE) || bus.in_req) && !in_valid_q) ||
                       (((ostate_q != O_IDLE) || bus.out_req) && !out_ready_q);
endmodule

// File: tb/tb_multicycle_io_buffer.sv
// Directed bench for multicycle_io_buffer (XLEN=32, RX_DEPTH=4, TX_DEPTH=2).
module tb_multicycle_io_buffer;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    multicycle_io_buffer_if #(.XLEN(32), .RX_DEPTH(4), .TX_DEPTH(2)) bus ();

    multicycle_io_buffer #(.XLEN(32), .RX_DEPTH(4), .TX_DEPTH(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    // UART transmitter model: busy for busy_len cycles after each start, or stuck high
    int         busy_len   = 10;
    int         busy_left  = 0;
    bit         busy_stuck = 1'b0;
    bit         prev_start = 1'b0;
    int         tx_viol    = 0;
    logic [7:0] txq [$];

    assign bus.tx_busy = busy_stuck || (busy_left != 0);

    // Record started bytes and flag starts while busy or back-to-back
    always @(negedge clk) begin
        if (bus.tx_start) begin
            if (bus.tx_busy || prev_start) tx_viol++;
            txq.push_back(bus.tx_data);
            busy_left = busy_len;
        end else if (busy_left != 0) begin
            busy_left--;
        end
        prev_start = bus.tx_start;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] d);
        bus.rx_data  = d;
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic wait_in_valid(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick(1);
            if (bus.in_valid) seen = 1'b1;
        end
    endtask

    task automatic wait_out_ready(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick(1);
            if (bus.out_ready) seen = 1'b1;
        end
    endtask

    initial begin
        bit         seen;
        bit         stall_low;
        bit         early;
        logic [7:0] word_bytes [4];
        logic [7:0] exp_tx [8];

        word_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
        exp_tx     = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02, 8'h03, 8'h04};

        // Reset, with an rx_ready strobe inside the reset cycle
        rstn         = 1'b0;
        bus.in_req   = 1'b0;
        bus.in_word  = 1'b0;
        bus.out_req  = 1'b0;
        bus.out_word = 1'b0;
        bus.out_data = '0;
        bus.rx_data  = 8'hAA;
        bus.rx_ready = 1'b1;
        tick(2);
        bus.rx_ready = 1'b0;
        check("rst_in_valid",  bus.in_valid,    1'b0);
        check("rst_out_ready", bus.out_ready,   1'b0);
        check("rst_tx_start",  bus.tx_start,    1'b0);
        check("rst_stall",     bus.stall,       1'b0);
        check("rst_in_data",   bus.in_data,     32'h0);
        check("rst_tx_data",   bus.tx_data,     8'h00);
        check("rst_rx_count",  bus.rx_count,    3'd0);
        check("rst_tx_count",  bus.tx_count,    2'd0);
        check("rst_overflow",  bus.rx_overflow, 1'b0);
        rstn = 1'b1;
        tick(1);
        check("rst_strobe_dropped", bus.rx_count, 3'd0);

        // Byte read of a buffered 0x41: in_valid two cycles after in_req
        push_byte(8'h41);
        check("b_rx_count_1", bus.rx_count, 3'd1);
        bus.in_req  = 1'b1;
        bus.in_word = 1'b0;
        tick(1);
        check("b_valid_early", bus.in_valid, 1'b0);
        check("b_stall",       bus.stall,    1'b1);
        tick(1);
        check("b_valid",      bus.in_valid, 1'b1);
        check("b_data",       bus.in_data,  32'h0000_0041);
        check("b_rx_count_0", bus.rx_count, 3'd0);
        check("b_stall_done", bus.stall,    1'b0);
        bus.in_req = 1'b0;
        tick(1);
        check("b_valid_pulse", bus.in_valid, 1'b0);

        // Word read issued first, bytes arrive 5 cycles apart
        bus.in_req  = 1'b1;
        bus.in_word = 1'b1;
        stall_low   = 1'b0;
        early       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 5; j++) begin
                tick(1);
                if (!bus.stall)   stall_low = 1'b1;
                if (bus.in_valid) early     = 1'b1;
            end
            push_byte(word_bytes[i]);
            if (!bus.stall)   stall_low = 1'b1;
            if (bus.in_valid) early     = 1'b1;
        end
        check("w_stall_held", stall_low, 1'b0);
        check("w_no_early",   early,     1'b0);
        tick(1);
        check("w_valid", bus.in_valid, 1'b1);
        check("w_data",  bus.in_data,  32'h1234_5678);
        check("w_stall", bus.stall,    1'b0);
        bus.in_req = 1'b0;
        tick(1);

        // Full RX FIFO: simultaneous push and pop keeps occupancy, no overflow
        push_byte(8'hC0);
        push_byte(8'hC1);
        push_byte(8'hC2);
        push_byte(8'hC3);
        check("f_rx_count_full", bus.rx_count, 3'd4);
        bus.in_req  = 1'b1;
        bus.in_word = 1'b0;
        tick(1);
        bus.rx_data  = 8'hC4;
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        check("f_valid",    bus.in_valid,    1'b1);
        check("f_data",     bus.in_data,     32'h0000_00C0);
        check("f_rx_count", bus.rx_count,    3'd4);
        check("f_no_ovf",   bus.rx_overflow, 1'b0);
        bus.in_req = 1'b0;
        tick(1);
        bus.in_req  = 1'b1;
        bus.in_word = 1'b1;
        wait_in_valid(20, seen);
        bus.in_req = 1'b0;
        check("f_word_seen",   seen,         1'b1);
        check("f_word_data",   bus.in_data,  32'hC4C3_C2C1);
        check("f_rx_count_0",  bus.rx_count, 3'd0);
        tick(1);

        // Overflow: 5 bytes into a 4-deep FIFO
        push_byte(8'hD0);
        push_byte(8'hD1);
        push_byte(8'hD2);
        push_byte(8'hD3);
        push_byte(8'hD4);
        check("o_rx_count", bus.rx_count,    3'd4);
        check("o_overflow", bus.rx_overflow, 1'b1);
        bus.in_req  = 1'b1;
        bus.in_word = 1'b1;
        wait_in_valid(20, seen);
        bus.in_req = 1'b0;
        check("o_word_seen",     seen,            1'b1);
        check("o_word_data",     bus.in_data,     32'hD3D2_D1D0);
        check("o_overflow_held", bus.rx_overflow, 1'b1);
        tick(1);

        // Word output 0xDEADBEEF; later changes of out_data must be ignored
        bus.out_req  = 1'b1;
        bus.out_word = 1'b1;
        bus.out_data = 32'hDEAD_BEEF;
        tick(1);
        bus.out_data = 32'h0000_0000;
        check("t_stall", bus.stall, 1'b1);
        wait_out_ready(300, seen);
        bus.out_req = 1'b0;
        check("t_ready_seen", seen, 1'b1);
        tick(1);
        check("t_ready_pulse", bus.out_ready, 1'b0);
        tick(120);
        check("t_start_count", txq.size(), 32'd4);
        check("t_tx_count_0",  bus.tx_count, 2'd0);

        // Transmitter stuck busy: out_ready withheld until it releases
        busy_stuck   = 1'b1;
        bus.out_req  = 1'b1;
        bus.out_word = 1'b1;
        bus.out_data = 32'h0403_0201;
        wait_out_ready(30, seen);
        check("s_ready_withheld", seen,         1'b0);
        check("s_stall",          bus.stall,    1'b1);
        check("s_tx_count_full",  bus.tx_count, 2'd2);
        busy_stuck = 1'b0;
        wait_out_ready(300, seen);
        bus.out_req = 1'b0;
        check("s_ready_seen", seen, 1'b1);
        tick(120);
        check("s_start_count", txq.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < txq.size()) check($sformatf("tx_byte_%0d", i), txq[i], exp_tx[i]);
        end
        check("tx_no_violation", tx_viol, 32'd0);

        // Reset after 2 of 4 word bytes collected
        bus.in_req  = 1'b1;
        bus.in_word = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        tick(1);
        check("r_stall_before", bus.stall,       1'b1);
        check("r_ovf_before",   bus.rx_overflow, 1'b1);
        rstn       = 1'b0;
        bus.in_req = 1'b0;
        tick(1);
        rstn = 1'b1;
        check("r_rx_count", bus.rx_count,    3'd0);
        check("r_stall",    bus.stall,       1'b0);
        check("r_overflow", bus.rx_overflow, 1'b0);
        check("r_in_data",  bus.in_data,     32'h0);
        wait_in_valid(10, seen);
        check("r_no_valid", seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/multicycle_io_buffer.md
MULTICYCLE_IO_BUFFER -- requirements
Module: multicycle_io_buffer

Interface
REQ-001 Parameter XLEN, default 32, CPU word width; SHALL be a multiple of 8, at least 8.
REQ-002 Parameter RX_DEPTH, default 16, RX FIFO entries; SHALL be a power of 2, at least 2.
REQ-003 Parameter TX_DEPTH, default 16, TX FIFO entries; SHALL be a power of 2, at least 2.
REQ-004 Clock and reset SHALL be: clk in 1, rising-edge clock; rstn in 1, reset, synchronous, active-low.
REQ-005 CPU input-request ports SHALL be:
- in_req  in  1  input request, level, held until in_valid
- in_word  in  1  1 = word mode, 0 = byte mode; sampled at acceptance
- in_valid  out  1  one-cycle pulse when in_data is complete
- in_data  out  XLEN  received data; held until the next in_valid
REQ-006 CPU output-request ports SHALL be:
- out_req  in  1  output request, level, held until out_ready
- out_word  in  1  1 = send XLEN/8 bytes, 0 = send out_data[7:0]
- out_data  in  XLEN  data to send
- out_ready  out  1  one-cycle pulse when all bytes are queued
REQ-007 stall out 1 SHALL be high while an accepted in_req or out_req has not yet completed.
REQ-008 UART ports SHALL be:
- rx_data  in  8, with rx_ready  in  1  one-cycle byte strobe
- tx_data  out  8, with tx_start  out  1  one-cycle start pulse
- tx_busy  in  1  transmitter busy
REQ-009 Status ports SHALL be:
- rx_count  out  clog2(RX_DEPTH)+1  RX FIFO occupancy
- tx_count  out  clog2(TX_DEPTH)+1  TX FIFO occupancy
- rx_overflow  out  1  sticky flag

Function
REQ-010 RX FIFO push: rx_ready with the FIFO not full SHALL push rx_data.
REQ-011 RX FIFO overflow: rx_ready with the FIFO full and no pop in the same cycle SHALL drop the byte and set rx_overflow; rx_overflow SHALL stay set until reset.
REQ-012 RX FIFO simultaneous push and pop: the pop SHALL complete and the push SHALL be accepted even when full; rx_count SHALL be unchanged.
REQ-013 Input FSM states SHALL be I_IDLE, I_COLLECT, I_DONE.
- I_IDLE: in_req high SHALL clear the byte index k to 0, latch in_word and go to I_COLLECT.
- I_COLLECT: each cycle the RX FIFO is non-empty SHALL pop one byte into in_data[8k+7:8k].
- Byte mode SHALL zero in_data[XLEN-1:8].
- Word mode SHALL fill bytes LSB first.
- After the last byte (1 byte in byte mode, XLEN/8 in word mode), the FSM SHALL go to I_DONE.
- I_DONE: in_valid SHALL pulse for one cycle and the FSM SHALL return to I_IDLE.
REQ-014 Input latency with bytes already buffered SHALL be: byte mode, in_valid 2 cycles after in_req rises; word mode, XLEN/8+1 cycles.
REQ-015 in_req held high in the cycle after in_valid SHALL start a new transaction.
REQ-016 Output FSM states SHALL be O_IDLE, O_PUSH, O_DONE.
- O_IDLE: out_req high SHALL capture out_data and out_word into a shift register and go to O_PUSH.
- O_PUSH: one byte, LSB first, SHALL be pushed per cycle the TX FIFO is not full.
- After the last byte, the FSM SHALL go to O_DONE.
- O_DONE: out_ready SHALL pulse for one cycle and the FSM SHALL return to O_IDLE.
REQ-017 out_data changes after capture SHALL be ignored.
REQ-018 The input and output FSMs SHALL operate independently and concurrently.
REQ-019 TX drain FSM states SHALL be T_IDLE, T_START, T_WAIT.
- T_IDLE: with the FIFO non-empty and tx_busy low, it SHALL drive tx_data with the head, pulse tx_start, pop and go to T_START.
- T_START SHALL go to T_WAIT unconditionally.
- T_WAIT SHALL go to T_IDLE when tx_busy is low.
REQ-020 tx_start SHALL never be asserted while tx_busy is high or in consecutive cycles.
REQ-021 A TX push and a TX pop in the same cycle SHALL leave tx_count unchanged.
REQ-022 FIFO pointers SHALL wrap modulo depth; full/empty SHALL be distinguished by occupancy counters, not pointer equality.
REQ-023 stall SHALL be combinational: (input FSM not I_IDLE or in_req) and not in_valid, or (output FSM not O_IDLE or out_req) and not out_ready.

Reset
REQ-024 rstn low at a rising edge SHALL empty both FIFOs, zero the pointers and counters, clear rx_overflow, and return all FSMs to idle.
REQ-025 Reset values SHALL be: in_valid, out_ready, tx_start, stall = 0; in_data = 0; tx_data = 0.
REQ-026 Reset mid-operation SHALL abandon any partial word or partial transmit; no completion pulse SHALL follow.
REQ-027 An rx_ready strobe in the reset cycle SHALL be discarded.

Verification
REQ-028 Bench SHALL cover: push 0x41, then in_req byte mode -> in_valid 2 cycles later, in_data=0x00000041, rx_count=0.
REQ-029 Bench SHALL cover: in_req word mode first, then bytes 78,56,34,12 spaced 5 cycles apart -> stall held until the 4th byte, in_data=0x12345678.
REQ-030 Bench SHALL cover: RX_DEPTH=4, 5 bytes pushed with no pops -> rx_count=4, rx_overflow=1, reads return the first 4 bytes.
REQ-031 Bench SHALL cover: word out 0xDEADBEEF, tx_busy modelled for 10 cycles per byte -> tx_data sequence EF,BE,AD,DE, exactly 4 tx_start pulses, none while busy.
REQ-032 Bench SHALL cover: TX_DEPTH=2, tx_busy stuck high, word out -> out_ready withheld, stall high; out_ready follows once tx_busy releases.
REQ-033 Bench SHALL cover: 2 of 4 word bytes collected, rstn low for 1 cycle -> no in_valid, rx_count=0, stall=0, rx_overflow=0.
